hs4_protocol_checker: RTL and testbench

Synthesizable, parametrised monitor for N independent 4-phase (return-to-zero) req/ack channels. Each channel runs a protocol-tracking FSM with a watchdog timeout, raises sticky per-channel error flags, pulses on every completed handshake, and feeds a shared saturating error counter. It sits beside the handshake components in benches and emulation builds, replacing per-signal value checks and timeout waits with cycle-accurate hardware checking. Inputs must already be synchronous to `clk`.

---
 rtl/hs_chk_pkg.sv | 31 +++
 rtl/hs4_chk_ch.sv | 78 +++++++
 rtl/hs4_protocol_checker.sv | 84 ++++++++
 tb/tb_hs4_protocol_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_chk_pkg.sv
// Shared state type and transition helpers for the 4-phase req/ack checker.
// State encodings equal the {req,ack} value expected while in that state.
package hs_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REL  = 2'b01,
    REQ  = 2'b10,
    ACK  = 2'b11
  } t_hs_state;

  // Non-0/1 values fall to the default arm, so X/Z resyncs to IDLE.
  function automatic t_hs_state hs_state_of(input logic [1:0] i_ra);
    case (i_ra)
      2'b01:   return REL;
      2'b10:   return REQ;
      2'b11:   return ACK;
      default: return IDLE;
    endcase
  endfunction

  function automatic t_hs_state hs_next_legal(input t_hs_state i_s);
    case (i_s)
      IDLE:    return REQ;
      REQ:     return ACK;
      ACK:     return REL;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hs4_chk_ch.sv
// One monitored channel: protocol FSM, per-phase watchdog, sticky flags and
// single-cycle event strobes that feed the shared error counter.
module hs4_chk_ch
  import hs_chk_pkg::*;
#(
  parameter int TOUT   = 100,
  parameter int TOUT_W = 7
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_req,
  input  logic i_ack,
  output logic o_done,
  output logic o_err_proto,
  output logic o_err_tout,
  output logic o_ev_proto,
  output logic o_ev_tout
);

  localparam logic [TOUT_W-1:0] LP_LIM    = TOUT_W'(TOUT);
  localparam logic [TOUT_W-1:0] LP_LIM_M1 = TOUT_W'((TOUT == 0) ? 0 : TOUT - 1);

  t_hs_state         r_state;
  logic [TOUT_W-1:0] r_wd;
  logic              r_done;
  logic              r_err_proto;
  logic              r_err_tout;

  logic [1:0] w_ra;
  logic [1:0] w_cur_ra;
  logic [1:0] w_adv_ra;
  t_hs_state  w_state_nxt;
  logic       w_stay;
  logic       w_adv;
  logic       w_chg;
  logic       w_ev_proto;
  logic       w_ev_tout;

  assign w_ra        = {i_req, i_ack};
  assign w_cur_ra    = r_state;
  assign w_adv_ra    = hs_next_legal(r_state);
  assign w_state_nxt = hs_state_of(w_ra);

  // 4-state compares so any X/Z on req/ack is neither a hold nor a legal step.
  assign w_stay     = (w_ra === w_cur_ra);
  assign w_adv      = (w_ra === w_adv_ra);
  assign w_chg      = (w_state_nxt != r_state);
  assign w_ev_proto = i_en && !w_stay && !w_adv;
  assign w_ev_tout  = (TOUT != 0) && i_en && !w_chg && (r_state != IDLE) &&
                      (r_wd == LP_LIM_M1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_wd        <= '0;
      r_done      <= 1'b0;
      r_err_proto <= 1'b0;
      r_err_tout  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_done      <= i_en && w_adv && (r_state == REL);
      r_err_proto <= (r_err_proto && !i_clr) || w_ev_proto;
      r_err_tout  <= (r_err_tout && !i_clr) || w_ev_tout;
      // Watchdog parks at the limit so a long stall reports only once.
      if (!i_en || w_chg || (w_state_nxt == IDLE)) r_wd <= '0;
      else if (r_wd != LP_LIM)                     r_wd <= r_wd + TOUT_W'(1);
    end
  end

  assign o_done      = r_done;
  assign o_err_proto = r_err_proto;
  assign o_err_tout  = r_err_tout;
  assign o_ev_proto  = w_ev_proto;
  assign o_ev_tout   = w_ev_tout;

endmodule

// File: rtl/hs4_protocol_checker.sv
// N-channel 4-phase handshake monitor: per-channel checkers plus a shared
// saturating count of protocol and timeout events.
module hs4_protocol_checker
  import hs_chk_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int TOUT   = 100,
  parameter int TOUT_W = (TOUT < 1) ? 1 : $clog2(TOUT + 1),
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [N_CH-1:0]   i_req,
  input  logic [N_CH-1:0]   i_ack,
  output logic [N_CH-1:0]   o_done,
  output logic [N_CH-1:0]   o_err_proto,
  output logic [N_CH-1:0]   o_err_tout,
  output logic              o_err_any,
  output logic [CNT_W-1:0]  o_err_cnt
);

  localparam int EV_W  = $clog2(2 * N_CH + 1);
  localparam int SUM_W = CNT_W + EV_W;
  localparam logic [SUM_W-1:0] LP_MAX = SUM_W'((64'd1 << CNT_W) - 64'd1);

  logic [N_CH-1:0]  w_ev_proto;
  logic [N_CH-1:0]  w_ev_tout;
  logic [N_CH-1:0]  w_err_proto;
  logic [N_CH-1:0]  w_err_tout;
  logic [EV_W-1:0]  w_ev_cnt;
  logic [CNT_W-1:0] w_base;
  logic [SUM_W-1:0] w_sum;

  logic [CNT_W-1:0] r_cnt;
  logic             r_any;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    hs4_chk_ch #(
      .TOUT   (TOUT),
      .TOUT_W (TOUT_W)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_en        (i_en),
      .i_clr       (i_clr),
      .i_req       (i_req[g]),
      .i_ack       (i_ack[g]),
      .o_done      (o_done[g]),
      .o_err_proto (w_err_proto[g]),
      .o_err_tout  (w_err_tout[g]),
      .o_ev_proto  (w_ev_proto[g]),
      .o_ev_tout   (w_ev_tout[g])
    );
  end

  always_comb begin
    w_ev_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_ev_cnt = w_ev_cnt + EV_W'(w_ev_proto[i]) + EV_W'(w_ev_tout[i]);
    end
  end

  // A clear in the same cycle as new events restarts the count at those events.
  assign w_base = i_clr ? '0 : r_cnt;
  assign w_sum  = SUM_W'(w_base) + SUM_W'(w_ev_cnt);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_any <= 1'b0;
    end else begin
      r_cnt <= (w_sum > LP_MAX) ? '1 : w_sum[CNT_W-1:0];
      r_any <= |(((w_err_proto | w_err_tout) & ~{N_CH{i_clr}}) | w_ev_proto | w_ev_tout);
    end
  end

  assign o_err_proto = w_err_proto;
  assign o_err_tout  = w_err_tout;
  assign o_err_any   = r_any;
  assign o_err_cnt   = r_cnt;

endmodule

// File: tb/tb_hs4_protocol_checker.sv
// Bench for hs4_protocol_checker: vector table, directed corner sequences and
// randomized traffic checked against a phase-counting reference model.
module tb_hs4_protocol_checker;

  localparam int N    = 4;
  localparam int TOUT = 8;

  logic         clk = 1'b0;
  logic         rst_n, en, clr;
  logic [N-1:0] req, ack;

  logic [N-1:0] done_a, proto_a, tout_a;
  logic         any_a;
  logic [7:0]   cnt_a;
  logic [N-1:0] done_b, proto_b, tout_b;
  logic         any_b;
  logic [1:0]   cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hs4_protocol_checker #(.N_CH(N), .TOUT(TOUT), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_req(req), .i_ack(ack),
    .o_done(done_a), .o_err_proto(proto_a), .o_err_tout(tout_a),
    .o_err_any(any_a), .o_err_cnt(cnt_a));

  hs4_protocol_checker #(.N_CH(N), .TOUT(TOUT), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_req(req), .i_ack(ack),
    .o_done(done_b), .o_err_proto(proto_b), .o_err_tout(tout_b),
    .o_err_any(any_b), .o_err_cnt(cnt_b));

  // Reference model: phase = number of legal steps taken mod 4 along 00,10,11,01.
  int           m_ph[N];
  int           m_hold[N];
  logic [N-1:0] m_done, m_proto, m_tout;
  int           m_total;

  function automatic int idx_of(input logic [1:0] v);
    if (v === 2'b00) return 0;
    if (v === 2'b10) return 1;
    if (v === 2'b11) return 2;
    if (v === 2'b01) return 3;
    return -1;
  endfunction

  task automatic model_step();
    int np;
    int nev;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_ph[i]   = 0;
        m_hold[i] = 0;
      end
      m_done = '0; m_proto = '0; m_tout = '0; m_total = 0;
    end else begin
      nev = 0;
      if (clr) begin
        m_proto = '0; m_tout = '0; m_total = 0;
      end
      for (int i = 0; i < N; i++) begin
        np = idx_of({req[i], ack[i]});
        m_done[i] = 1'b0;
        if (en) begin
          if (np < 0 || (np != m_ph[i] && np != (m_ph[i] + 1) % 4)) begin
            m_proto[i] = 1'b1;
            nev++;
          end else if (m_ph[i] == 3 && np == 0) begin
            m_done[i] = 1'b1;
          end
          if (np < 0) np = 0;
          if (np != m_ph[i] || np == 0) m_hold[i] = 0;
          else                          m_hold[i]++;
          if (m_hold[i] == TOUT) begin
            m_tout[i] = 1'b1;
            nev++;
          end
        end else begin
          if (np < 0) np = 0;
          m_hold[i] = 0;
        end
        m_ph[i] = np;
      end
      m_total += nev;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_done",   done_a,  m_done);
    chk("m_proto",  proto_a, m_proto);
    chk("m_tout",   tout_a,  m_tout);
    chk("m_any",    any_a,   |(m_proto | m_tout));
    chk("m_cnt",    cnt_a,   (m_total > 255) ? 255 : m_total);
    chk("m_done_b", done_b,  m_done);
    chk("m_proto_b",proto_b, m_proto);
    chk("m_tout_b", tout_b,  m_tout);
    chk("m_any_b",  any_b,   |(m_proto | m_tout));
    chk("m_cnt_b",  cnt_b,   (m_total > 3) ? 3 : m_total);
  endtask

  task automatic cyc(input logic r, input logic e, input logic c,
                     input logic [N-1:0] rq, input logic [N-1:0] ak);
    rst_n = r; en = e; clr = c; req = rq; ack = ak;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] ack;
    logic         clr;
    logic [N-1:0] done;
    logic [N-1:0] proto;
    logic [7:0]   cnt;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] rq, input logic [N-1:0] ak, input logic c,
                              input logic [N-1:0] d, input logic [N-1:0] p, input logic [7:0] n);
    vec_t v;
    v.req = rq; v.ack = ak; v.clr = c; v.done = d; v.proto = p; v.cnt = n;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] cr, ca;
    logic [N-1:0] xr;

    // legal handshake on ch0, two cycles per phase
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0));
    // ack on ch1 without req: resync to REL, then ack falling completes it
    tbl.push_back(mk(4'b0000, 4'b0010, 0, 4'b0000, 4'b0010, 1));
    tbl.push_back(mk(4'b0000, 4'b0010, 0, 4'b0000, 4'b0010, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b0010, 4'b0010, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0010, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0));
    // simultaneous violations on ch0/ch3 with clear: new events win
    tbl.push_back(mk(4'b0000, 4'b1001, 1, 4'b0000, 4'b1001, 2));
    tbl.push_back(mk(4'b0000, 4'b1001, 1, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b1001, 4'b0000, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0));

    cyc(0, 0, 0, '0, '0);
    cyc(0, 1, 1, 4'b1111, 4'b0101);
    chk("rst_done", done_a, 0);
    chk("rst_proto", proto_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_any", any_a, 0);
    cyc(0, 0, 0, '0, '0);

    foreach (tbl[i]) begin
      cyc(1, 1, tbl[i].clr, tbl[i].req, tbl[i].ack);
      chk($sformatf("vec%0d_done", i),  done_a,  tbl[i].done);
      chk($sformatf("vec%0d_proto", i), proto_a, tbl[i].proto);
      chk($sformatf("vec%0d_tout", i),  tout_a,  0);
      chk($sformatf("vec%0d_cnt", i),   cnt_a,   tbl[i].cnt);
    end

    // watchdog on ch2: REQ entered at the first edge, flag exactly TOUT edges later
    cyc(1, 1, 0, 4'b0100, 4'b0000);
    chk("tout_entry", tout_a, 0);
    for (int i = 1; i <= TOUT; i++) begin
      cyc(1, 1, 0, 4'b0100, 4'b0000);
      chk($sformatf("tout_hold%0d", i), tout_a, (i == TOUT) ? 4'b0100 : 4'b0000);
    end
    chk("tout_cnt", cnt_a, 1);
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 4'b0100, 4'b0000);
    chk("tout_sat_flag", tout_a, 4'b0100);
    chk("tout_sat_cnt", cnt_a, 1);
    cyc(1, 1, 0, 4'b0100, 4'b0100);
    cyc(1, 1, 0, 4'b0000, 4'b0100);
    cyc(1, 1, 0, 4'b0000, 4'b0000);
    chk("tout_done", done_a, 4'b0100);
    chk("tout_proto", proto_a, 0);
    cyc(1, 1, 1, 4'b0000, 4'b0000);

    // unknown on req[0]; expectation comes from the model's own X handling
    xr = 4'b000x;
    cyc(1, 1, 0, xr, 4'b0000);
    cyc(1, 1, 0, 4'b0000, 4'b0000);
    cyc(1, 1, 1, 4'b0000, 4'b0000);

    // saturation of the 2-bit counter
    cyc(1, 1, 0, 4'b1111, 4'b1111);
    chk("sat_proto", proto_a, 4'b1111);
    chk("sat_cnt_a", cnt_a, 4);
    chk("sat_cnt_b", cnt_b, 3);
    cyc(1, 1, 0, 4'b1111, 4'b1111);
    cyc(1, 1, 0, 4'b0000, 4'b0000);
    chk("sat_cnt_a2", cnt_a, 8);
    chk("sat_cnt_b2", cnt_b, 3);
    cyc(1, 1, 1, 4'b0000, 4'b0000);
    chk("clr_cnt_b", cnt_b, 0);

    // reset mid-handshake, then silent resync with en low
    cyc(1, 1, 0, 4'b0001, 4'b0000);
    cyc(1, 1, 0, 4'b0001, 4'b0001);
    cyc(0, 1, 1, 4'b0001, 4'b0001);
    chk("mid_rst_proto", proto_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_any", any_a, 0);
    cyc(1, 0, 0, 4'b0001, 4'b0001);
    chk("en_off_proto", proto_a, 0);
    cyc(1, 1, 0, 4'b0000, 4'b0001);
    chk("en_on_rel", proto_a, 0);
    cyc(1, 1, 0, 4'b0000, 4'b0000);
    chk("en_on_done", done_a, 4'b0001);

    // randomized traffic: mostly holds and legal steps, some arbitrary jumps
    cr = '0; ca = '0;
    cyc(0, 0, 0, cr, ca);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 20) begin
          if (cr[i] == ca[i]) cr[i] = ~cr[i];
          else                ca[i] = ~ca[i];
        end else if (r < 26) begin
          cr[i] = 1'($urandom);
          ca[i] = 1'($urandom);
        end
      end
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 19) != 0),
          ($urandom_range(0, 59) == 0), cr, ca);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
